pwm_y_decoder: RTL and testbench
================================

PWM_Y_DECODER -- requirements
Module: pwm_y_decoder

Interface
REQ-001 Parameter TICK_DIV, default 100: clk cycles per 1 us measurement tick (100 MHz clk).
REQ-002 Parameter PULSE_MIN_US, default 1000: pulse width mapped to y_val = 0.
REQ-003 Parameter PULSE_MAX_US, default 2000: pulse width mapped to y_val = PULSE_MAX_US - PULSE_MIN_US (1000).
REQ-004 Parameter ACC_MIN_US / ACC_MAX_US, defaults 500 / 2500: accept window; widths outside it are errors.
REQ-005 Parameter TIMEOUT_US, default 25000: maximum us without a rising edge before signal is declared lost.
REQ-006 Parameter Y_CENTER, default 500: y_val failsafe and reset value.
REQ-007 clk  input  1  single system clock; all logic on its rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 pwm_in  input  1  asynchronous servo-style PWM pulse train (high pulse ~1-2 ms, period ~20 ms).
REQ-010 y_val  output  11  decoded steering value, registered.
REQ-011 y_valid  output  1  one-cycle strobe on each y_val update from an accepted pulse.
REQ-012 pulse_err  output  1  last completed pulse was outside the accept window.
REQ-013 sig_lost  output  1  no valid PWM activity; y_val is at failsafe.

Function
REQ-014 pwm_in SHALL pass through a 2-FF synchronizer plus one edge-detect register; rise/fall are detected on the synchronized signal only.
REQ-015 FSM states SHALL be: SYNC (wait for synchronized low), WAIT_RISE, HIGH.
REQ-016 SYNC -> WAIT_RISE when synchronized pwm_in is low; no measurement occurs in SYNC.
REQ-017 WAIT_RISE -> HIGH on rising edge; width counter cleared to 0 and tick prescaler restarted at 0 in that cycle.
REQ-018 In HIGH, width counter (12 bit) SHALL increment once per tick (prescaler reaching TICK_DIV-1) and saturate at 4095.
REQ-019 HIGH -> WAIT_RISE on falling edge; width evaluated in the same cycle.
REQ-020 Accepted pulse (ACC_MIN_US <= width <= ACC_MAX_US): y_val <= clamp(width, PULSE_MIN_US, PULSE_MAX_US) - PULSE_MIN_US; y_valid = 1 for one cycle; pulse_err <= 0; sig_lost <= 0.
REQ-021 Rejected pulse: y_val held, no y_valid, pulse_err <= 1, sig_lost unchanged.
REQ-022 y_val/y_valid SHALL update 3 clk cycles after the first rising clk edge that samples pwm_in low (2 sync + 1 edge/evaluate).
REQ-023 Timeout counter (15 bit) SHALL count ticks in all states, clear on every rising edge, and not wrap.
REQ-024 When timeout counter reaches TIMEOUT_US: sig_lost <= 1, y_val <= Y_CENTER, no y_valid, FSM -> SYNC, counter cleared.
REQ-025 A pin stuck high SHALL cause timeout via REQ-024 and then remain in SYNC until low; a pin stuck low SHALL time out from WAIT_RISE.
REQ-026 Simultaneous falling edge and timeout in one cycle: timeout wins; pulse discarded.
REQ-027 Quantisation SHALL be 1 tick (1 us); a pulse of exactly N*TICK_DIV cycles decodes to width N.

Reset
REQ-028 On rst low, asynchronously: FSM = SYNC, all counters 0, synchronizer regs 0, y_val = Y_CENTER, y_valid = 0, pulse_err = 0, sig_lost = 1.
REQ-029 A pulse already high when rst deasserts SHALL be ignored (SYNC waits for low first); reset mid-pulse discards it.

Verification
REQ-030 1500 us pulse, 20 ms period -> y_val = 500, y_valid strobe 3 cycles after fall, sig_lost = 0, pulse_err = 0.
REQ-031 1000 us -> y_val = 0; 2000 us -> 1000; 2200 us -> 1000 (clamped); 800 us -> 0 (clamped); all with y_valid.
REQ-032 300 us and 3000 us pulses after a good 1200 us pulse -> pulse_err = 1, y_val stays 200, no y_valid; next 1500 us pulse -> pulse_err = 0, y_val = 500.
REQ-033 Good pulses, then pwm_in held low 25 ms -> sig_lost = 1, y_val = 500; held high instead -> same, then first complete 1700 us pulse after low -> y_val = 700, sig_lost = 0.
REQ-034 rst released with pwm_in high (pulse in progress) -> no y_valid for that pulse; following 1600 us pulse -> y_val = 600.
REQ-035 rst asserted for 2 cycles mid-HIGH after prior y_val = 900 -> outputs immediately Y_CENTER/0/0/1; subsequent full pulse decodes correctly.

Source files
------------

// File: rtl/pwm_y_decoder.sv
// Servo-style PWM pulse-width decoder: measures the high time of pwm_in in
// 1 us ticks and maps it to an 11-bit steering value with loss-of-signal failsafe.
module pwm_y_decoder #(
    parameter int TICK_DIV     = 100,
    parameter int PULSE_MIN_US = 1000,
    parameter int PULSE_MAX_US = 2000,
    parameter int ACC_MIN_US   = 500,
    parameter int ACC_MAX_US   = 2500,
    parameter int TIMEOUT_US   = 25000,
    parameter int Y_CENTER     = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm_in,
    output logic [10:0] y_val,
    output logic        y_valid,
    output logic        pulse_err,
    output logic        sig_lost
);

    typedef enum logic [1:0] {
        SYNC,
        WAIT_RISE,
        HIGH
    } state_t;

    localparam int              PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [14:0]     TO_LAST   = 15'(TIMEOUT_US - 1);
    localparam logic [11:0]     WIDTH_SAT = 12'hFFF;
    localparam logic [10:0]     Y_CTR     = 11'(Y_CENTER);
    localparam logic [10:0]     Y_SPAN    = 11'(PULSE_MAX_US - PULSE_MIN_US);

    state_t             state_q;
    logic               sync1_q, sync2_q, edge_q;
    logic [1:0]         fill_q;
    logic [PRE_W-1:0]   presc_q;
    logic [11:0]        width_q;
    logic [14:0]        to_q;
    logic [10:0]        y_val_q;
    logic               y_valid_q, pulse_err_q, sig_lost_q;

    logic               rise, fall, tick, to_hit, accept;
    logic [11:0]        width_meas;
    logic [10:0]        y_d;
    int                 width_int;

    assign rise   = sync2_q & ~edge_q;
    assign fall   = ~sync2_q & edge_q;
    assign tick   = (presc_q == PRE_LAST);
    // A live rising edge proves the signal is present, so it pre-empts a timeout.
    assign to_hit = tick && (to_q == TO_LAST) && !rise;

    // The tick landing on the evaluating edge still belongs to the pulse, so that
    // exactly N*TICK_DIV high cycles decode to N.
    assign width_meas = (tick && width_q != WIDTH_SAT) ? width_q + 12'd1 : width_q;

    // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        width_int = int'({20'd0, width_meas});
        accept    = (width_int >= ACC_MIN_US) && (width_int <= ACC_MAX_US);
        y_d       = '0;
        if (width_int >= PULSE_MAX_US) begin
            y_d = Y_SPAN;
        end else if (width_int > PULSE_MIN_US) begin
            y_d = 11'(width_int - PULSE_MIN_US);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SYNC;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            edge_q      <= 1'b0;
            fill_q      <= '0;
            presc_q     <= '0;
            width_q     <= '0;
            to_q        <= '0;
            y_val_q     <= Y_CTR;
            y_valid_q   <= 1'b0;
            pulse_err_q <= 1'b0;
            sig_lost_q  <= 1'b1;
        end else begin
            sync1_q   <= pwm_in;
            sync2_q   <= sync1_q;
            edge_q    <= sync2_q;
            y_valid_q <= 1'b0;

            // Reset values in the synchronizer are not real samples; SYNC waits them out.
            if (fill_q != 2'd2) begin
                fill_q <= fill_q + 2'd1;
            end

            if (rise || tick) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + PRE_W'(1);
            end

            if (rise || to_hit) begin
                to_q <= '0;
            end else if (tick) begin
                to_q <= to_q + 15'd1;
            end

            if (to_hit) begin
                state_q    <= SYNC;
                sig_lost_q <= 1'b1;
                y_val_q    <= Y_CTR;
            end else begin
                unique case (state_q)
                    SYNC: begin
                        if (fill_q == 2'd2 && !sync2_q) begin
                            state_q <= WAIT_RISE;
                        end
                    end
                    WAIT_RISE: begin
                        if (rise) begin
                            state_q <= HIGH;
                            width_q <= '0;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            state_q <= WAIT_RISE;
                            if (accept) begin
                                y_val_q     <= y_d;
                                y_valid_q   <= 1'b1;
                                pulse_err_q <= 1'b0;
                                sig_lost_q  <= 1'b0;
                            end else begin
                                pulse_err_q <= 1'b1;
                            end
                        end else begin
                            width_q <= width_meas;
                        end
                    end
                    default: state_q <= SYNC;
                endcase
            end
        end
    end

    assign y_val     = y_val_q;
    assign y_valid   = y_valid_q;
    assign pulse_err = pulse_err_q;
    assign sig_lost  = sig_lost_q;

endmodule

// File: tb/tb_pwm_y_decoder.sv
// Directed bench for pwm_y_decoder with a 2-cycle tick and 3500 us timeout so
// that every scenario fits in a short run; expectations are hand-computed.
module tb_pwm_y_decoder;

    localparam int TD  = 2;     // clk cycles per us in this bench
    localparam int TMO = 3500;  // timeout in us

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pwm_in = 1'b0;
    logic [10:0] y_val;
    logic        y_valid, pulse_err, sig_lost;

    int checks = 0;
    int failures = 0;

    pwm_y_decoder #(
        .TICK_DIV    (TD),
        .PULSE_MIN_US(1000),
        .PULSE_MAX_US(2000),
        .ACC_MIN_US  (500),
        .ACC_MAX_US  (2500),
        .TIMEOUT_US  (TMO),
        .Y_CENTER    (500)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pwm_in   (pwm_in),
        .y_val    (y_val),
        .y_valid  (y_valid),
        .pulse_err(pulse_err),
        .sig_lost (sig_lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Counts y_valid strobes over n edges and records the edge index of the last one.
    task automatic watch_valid(input int n, output int cnt, output int lat);
        cnt = 0;
        lat = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (y_valid) begin
                cnt++;
                lat = i;
            end
        end
    endtask

    // Drives a high pulse of hi_cycles clocks, then checks strobe count, strobe
    // latency (third edge, counting the one that first samples the low) and outputs.
    task automatic send_pulse(input string tag, input int hi_cycles, input bit exp_valid,
                              input int exp_y, input bit exp_err, input bit exp_lost);
        int cnt, lat;
        pwm_in = 1'b1;
        idle(hi_cycles);
        pwm_in = 1'b0;
        watch_valid(8, cnt, lat);
        check({tag, ".strobes"}, 32'(cnt), exp_valid ? 32'd1 : 32'd0);
        if (exp_valid) check({tag, ".latency"}, 32'(lat), 32'd3);
        check({tag, ".y_val"}, 32'(y_val), 32'(exp_y));
        check({tag, ".pulse_err"}, 32'(pulse_err), 32'(exp_err));
        check({tag, ".sig_lost"}, 32'(sig_lost), 32'(exp_lost));
    endtask

    initial begin
        int cnt, lat;

        // Power-on reset state
        idle(3);
        check("rst.y_val", 32'(y_val), 32'd500);
        check("rst.y_valid", 32'(y_valid), 32'd0);
        check("rst.pulse_err", 32'(pulse_err), 32'd0);
        check("rst.sig_lost", 32'(sig_lost), 32'd1);
        rst = 1'b1;
        idle(10);

        // Nominal decode and clamping
        send_pulse("p1500", 1500 * TD, 1, 500, 0, 0);   idle(60);
        send_pulse("p1000", 1000 * TD, 1, 0, 0, 0);     idle(60);
        send_pulse("p2000", 2000 * TD, 1, 1000, 0, 0);  idle(60);
        send_pulse("p2200", 2200 * TD, 1, 1000, 0, 0);  idle(60);
        send_pulse("p800",  800 * TD,  1, 0, 0, 0);     idle(60);

        // Rejections hold y_val; next good pulse clears the error
        send_pulse("p1200", 1200 * TD, 1, 200, 0, 0);   idle(60);
        send_pulse("p300",  300 * TD,  0, 200, 1, 0);   idle(60);
        send_pulse("p3000", 3000 * TD, 0, 200, 1, 0);   idle(60);
        send_pulse("p1500b", 1500 * TD, 1, 500, 0, 0);  idle(60);

        // Accept-window edges and 1-tick quantisation
        send_pulse("p500", 500 * TD, 1, 0, 0, 0);         idle(60);
        send_pulse("p2501", 2501 * TD, 0, 0, 1, 0);       idle(60);
        send_pulse("q1234p", 1234 * TD + 1, 1, 234, 0, 0); idle(60);
        send_pulse("q1234m", 1234 * TD - 1, 1, 233, 0, 0); idle(60);

        // Pin stuck low: timeout counted from the last rising edge
        send_pulse("p1700", 1700 * TD, 1, 700, 0, 0);
        idle((TMO - 100) * TD - (1700 * TD + 8));
        check("low.before_tmo.sig_lost", 32'(sig_lost), 32'd0);
        check("low.before_tmo.y_val", 32'(y_val), 32'd700);
        idle(200 * TD);
        check("low.after_tmo.sig_lost", 32'(sig_lost), 32'd1);
        check("low.after_tmo.y_val", 32'(y_val), 32'd500);
        check("low.after_tmo.pulse_err", 32'(pulse_err), 32'd0);
        send_pulse("recover1", 1500 * TD, 1, 500, 0, 0); idle(60);

        // Pin stuck high: timeout, then stay in SYNC until low, falling edge ignored
        pwm_in = 1'b1;
        idle((TMO + 100) * TD);
        check("high.tmo.sig_lost", 32'(sig_lost), 32'd1);
        check("high.tmo.y_val", 32'(y_val), 32'd500);
        pwm_in = 1'b0;
        watch_valid(8, cnt, lat);
        check("high.release.strobes", 32'(cnt), 32'd0);
        check("high.release.sig_lost", 32'(sig_lost), 32'd1);
        idle(60);
        send_pulse("recover2", 1700 * TD, 1, 700, 0, 0); idle(60);

        // Falling edge on the same edge as the timeout: timeout wins
        send_pulse("fall_vs_tmo", TMO * TD, 0, 500, 0, 1); idle(60);
        send_pulse("recover3", 1500 * TD, 1, 500, 0, 0);   idle(60);

        // Reset mid-pulse, released while the pin is still high
        send_pulse("p1900", 1900 * TD, 1, 900, 0, 0); idle(60);
        pwm_in = 1'b1;
        idle(500 * TD);
        rst = 1'b0;
        #1;
        check("midrst.y_val", 32'(y_val), 32'd500);
        check("midrst.y_valid", 32'(y_valid), 32'd0);
        check("midrst.pulse_err", 32'(pulse_err), 32'd0);
        check("midrst.sig_lost", 32'(sig_lost), 32'd1);
        idle(2);
        rst = 1'b1;
        idle(500 * TD);
        pwm_in = 1'b0;
        watch_valid(8, cnt, lat);
        check("postrst.strobes", 32'(cnt), 32'd0);
        check("postrst.sig_lost", 32'(sig_lost), 32'd1);
        check("postrst.y_val", 32'(y_val), 32'd500);
        idle(60);
        send_pulse("p1600", 1600 * TD, 1, 600, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
